// File: rtl/openmips_bus_pkg.sv
// Shared bus types for the instruction/data memory arbiter: widths, FSM
// state encoding, grant owner and the registered RAM request bundle.
package openmips_bus_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int SEL_W    = 4;
  localparam int CNT_W    = 3;   // holds WAIT_CYC up to 7
  localparam int STREAK_W = 4;   // holds MAX_STREAK up to 15

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

  // Data wins unless a fetch is also waiting and data has used up its streak.
  function automatic owner_e pick_owner(input logic if_req, input logic dm_req,
                                        input logic streak_ok);
    if (dm_req && (!if_req || streak_ok)) return OWN_DATA;
    return OWN_FETCH;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the RAM.
// slave = arbiter view, master = CPU/RAM side view.
interface mem_bus_arbiter_if;
  import openmips_bus_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic              dm_we;
  logic [SEL_W-1:0]  dm_sel;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              ram_ce;
  logic              ram_we;
  logic [SEL_W-1:0]  ram_sel;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              stall_req;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_sel, dm_addr, dm_wdata, ram_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, stall_req
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_sel, dm_addr, dm_wdata, ram_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, stall_req
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-RAM arbiter between instruction fetch and data ports.
// Each access: one IDLE arbitration cycle, WAIT_CYC+1 cycles with ram_ce
// held, then one DONE cycle carrying the owner's ack. A streak counter stops
// a busy data port from starving instruction fetch.
module mem_bus_arbiter
  import openmips_bus_pkg::*;
#(
  parameter int WAIT_CYC   = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_bus_arbiter_if.slave   bus
);

  arb_state_e          state_q;
  owner_e              owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STREAK_W-1:0] streak_q;
  ram_req_t            ram_q;
  logic                ce_q;
  logic                if_ack_q, dm_ack_q;
  logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;

  logic     any_req;
  logic     streak_ok;
  owner_e   grant_d;
  ram_req_t grant_req_d;

  assign any_req   = bus.if_req | bus.dm_req;
  assign streak_ok = streak_q < STREAK_W'(MAX_STREAK);
  assign grant_d   = pick_owner(bus.if_req, bus.dm_req, streak_ok);

  // Build the RAM request for whichever port wins arbitration this cycle.
  always_comb begin
    grant_req_d = '0;
    if (grant_d == OWN_DATA) begin
      grant_req_d.we    = bus.dm_we;
      grant_req_d.sel   = bus.dm_sel;
      grant_req_d.addr  = bus.dm_addr;
      grant_req_d.wdata = bus.dm_wdata;
    end else begin
      // fetch is always a full-word read
      grant_req_d.we    = 1'b0;
      grant_req_d.sel   = '1;
      grant_req_d.addr  = bus.if_addr;
      grant_req_d.wdata = '0;
    end
  end

  // Arbitration FSM: grant, hold RAM for the wait count, ack for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_FETCH;
      cnt_q      <= '0;
      streak_q   <= '0;
      ram_q      <= '0;
      ce_q       <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // a gap in data traffic ends the streak
          if (!bus.dm_req) streak_q <= '0;
          if (any_req) begin
            state_q <= ST_BUSY;
            owner_q <= grant_d;
            cnt_q   <= CNT_W'(WAIT_CYC);
            ram_q   <= grant_req_d;
            ce_q    <= 1'b1;
            if (grant_d == OWN_FETCH)
              streak_q <= '0;
            else if (bus.if_req && streak_q != STREAK_W'(MAX_STREAK))
              streak_q <= streak_q + 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            state_q  <= ST_DONE;
            ce_q     <= 1'b0;
            ram_q.we <= 1'b0;
            if (owner_q == OWN_FETCH) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.ram_rdata;
            end else begin
              dm_ack_q <= 1'b1;
              // writes leave the last read data in place
              if (!ram_q.we) dm_rdata_q <= bus.ram_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_ce    = ce_q;
  assign bus.ram_we    = ram_q.we;
  assign bus.ram_sel   = ram_q.sel;
  assign bus.ram_addr  = ram_q.addr;
  assign bus.ram_wdata = ram_q.wdata;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

  // Stall the pipeline while any port is waiting on an outstanding request.
  assign bus.stall_req = (bus.if_req & ~if_ack_q) | (bus.dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: cycle table on a WAIT_CYC=1 instance, plus hand sequences
// for starvation guard, reset mid-access (WAIT_CYC=3) and back-to-back
// zero-wait accesses (WAIT_CYC=0).
module tb_mem_bus_arbiter;
  import openmips_bus_pkg::*;

  typedef struct packed {
    logic        ce;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall;
  } obs_t;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_sel;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] ram_rdata;
  } stim_t;

  typedef struct {
    stim_t s;
    obs_t  e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst0_n, rst3_n;

  mem_bus_arbiter_if b1();
  mem_bus_arbiter_if b0();
  mem_bus_arbiter_if b3();

  mem_bus_arbiter #(.WAIT_CYC(1), .MAX_STREAK(4)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(b1));
  mem_bus_arbiter #(.WAIT_CYC(0), .MAX_STREAK(4)) dut0 (.clk(clk), .rst_n(rst0_n), .bus(b0));
  mem_bus_arbiter #(.WAIT_CYC(3), .MAX_STREAK(4)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(b3));

  obs_t o1, o0, o3;
  assign o1 = {b1.ram_ce, b1.ram_we, b1.ram_sel, b1.ram_addr, b1.ram_wdata,
               b1.if_ack, b1.if_rdata, b1.dm_ack, b1.dm_rdata, b1.stall_req};
  assign o0 = {b0.ram_ce, b0.ram_we, b0.ram_sel, b0.ram_addr, b0.ram_wdata,
               b0.if_ack, b0.if_rdata, b0.dm_ack, b0.dm_rdata, b0.stall_req};
  assign o3 = {b3.ram_ce, b3.ram_we, b3.ram_sel, b3.ram_addr, b3.ram_wdata,
               b3.if_ack, b3.if_rdata, b3.dm_ack, b3.dm_rdata, b3.stall_req};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic stim_t iv(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dw, input logic [3:0] ds, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [31:0] rr);
    return {ir, ia, dr, dw, ds, da, dwd, rr};
  endfunction

  function automatic obs_t ob(input logic ce, input logic we, input logic [3:0] sel,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic ia, input logic [31:0] ird,
                              input logic da, input logic [31:0] drd, input logic st);
    return {ce, we, sel, addr, wd, ia, ird, da, drd, st};
  endfunction

  task automatic drive1(input stim_t s);
    b1.if_req    = s.if_req;
    b1.if_addr   = s.if_addr;
    b1.dm_req    = s.dm_req;
    b1.dm_we     = s.dm_we;
    b1.dm_sel    = s.dm_sel;
    b1.dm_addr   = s.dm_addr;
    b1.dm_wdata  = s.dm_wdata;
    b1.ram_rdata = s.ram_rdata;
  endtask

  localparam logic [31:0] R  = 32'h3402_0020;
  localparam logic [31:0] A  = 32'h1111_2222;
  localparam logic [31:0] B  = 32'h3333_4444;
  localparam logic [31:0] W  = 32'h5555_5555;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  vec_t vt[16];

  initial begin
    int n, nce, ngr, na, last, bad, ifa, dma;
    logic flag, ovl, prev;

    // single fetch: ram_ce two cycles, ack on the third
    vt[0]  = '{iv(1, 32'h100, 0, 0, 4'h0, 0, 0, R), ob(1, 0, 4'hF, 32'h100, 0, 0, 0, 0, 0, 1)};
    vt[1]  = '{iv(1, 32'h100, 0, 0, 4'h0, 0, 0, R), ob(1, 0, 4'hF, 32'h100, 0, 0, 0, 0, 0, 1)};
    vt[2]  = '{iv(1, 32'h100, 0, 0, 4'h0, 0, 0, R), ob(0, 0, 4'hF, 32'h100, 0, 1, R, 0, 0, 0)};
    vt[3]  = '{iv(0, 32'h100, 0, 0, 4'h0, 0, 0, R), ob(0, 0, 4'hF, 32'h100, 0, 0, R, 0, 0, 0)};
    // simultaneous: data read first, fetch four cycles later
    vt[4]  = '{iv(1, 32'h104, 1, 0, 4'hF, 32'h200, 0, A), ob(1, 0, 4'hF, 32'h200, 0, 0, R, 0, 0, 1)};
    vt[5]  = '{iv(1, 32'h104, 1, 0, 4'hF, 32'h200, 0, A), ob(1, 0, 4'hF, 32'h200, 0, 0, R, 0, 0, 1)};
    vt[6]  = '{iv(1, 32'h104, 1, 0, 4'hF, 32'h200, 0, A), ob(0, 0, 4'hF, 32'h200, 0, 0, R, 1, A, 1)};
    vt[7]  = '{iv(1, 32'h104, 0, 0, 4'hF, 32'h200, 0, B), ob(0, 0, 4'hF, 32'h200, 0, 0, R, 0, A, 1)};
    vt[8]  = '{iv(1, 32'h104, 0, 0, 4'hF, 32'h200, 0, B), ob(1, 0, 4'hF, 32'h104, 0, 0, R, 0, A, 1)};
    vt[9]  = '{iv(1, 32'h104, 0, 0, 4'hF, 32'h200, 0, B), ob(1, 0, 4'hF, 32'h104, 0, 0, R, 0, A, 1)};
    vt[10] = '{iv(1, 32'h104, 0, 0, 4'hF, 32'h200, 0, B), ob(0, 0, 4'hF, 32'h104, 0, 1, B, 0, A, 0)};
    vt[11] = '{iv(0, 32'h104, 0, 0, 4'hF, 32'h200, 0, B), ob(0, 0, 4'hF, 32'h104, 0, 0, B, 0, A, 0)};
    // partial write: dm_rdata must keep the earlier read value
    vt[12] = '{iv(0, 32'h104, 1, 1, 4'h3, 32'h40, DB, W), ob(1, 1, 4'h3, 32'h40, DB, 0, B, 0, A, 1)};
    vt[13] = '{iv(0, 32'h104, 1, 1, 4'h3, 32'h40, DB, W), ob(1, 1, 4'h3, 32'h40, DB, 0, B, 0, A, 1)};
    vt[14] = '{iv(0, 32'h104, 1, 1, 4'h3, 32'h40, DB, W), ob(0, 0, 4'h3, 32'h40, DB, 0, B, 1, A, 0)};
    vt[15] = '{iv(0, 32'h104, 0, 1, 4'h3, 32'h40, DB, W), ob(0, 0, 4'h3, 32'h40, DB, 0, B, 0, A, 0)};

    rst1_n = 1'b0; rst0_n = 1'b0; rst3_n = 1'b0;
    drive1('0);
    b0.if_req = 0; b0.if_addr = 0; b0.dm_req = 0; b0.dm_we = 0; b0.dm_sel = 0;
    b0.dm_addr = 0; b0.dm_wdata = 0; b0.ram_rdata = 0;
    b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_sel = 0;
    b3.dm_addr = 0; b3.dm_wdata = 0; b3.ram_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dut1", o1, '0);
    chk("reset_dut0", o0, '0);
    chk("reset_dut3", o3, '0);
    @(negedge clk);
    rst1_n = 1'b1; rst0_n = 1'b1; rst3_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive1(vt[i].s);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), o1, vt[i].e);
    end

    // starvation guard: both held, expect D D D D F D D D D F
    @(negedge clk);
    drive1(iv(1, 32'h1000, 1, 0, 4'hF, 32'h2000, 0, 32'h77));
    ngr = 0; n = 0; prev = 1'b0;
    while (!(ngr == 10 && b1.if_ack) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (b1.ram_ce && !prev) begin
        chk($sformatf("streak_grant%0d_is_fetch", ngr), b1.ram_addr == 32'h1000,
            ngr == 4 || ngr == 9);
        ngr++;
      end
      prev = b1.ram_ce;
    end
    chk("streak_end", {ngr == 10, b1.if_ack}, 2'b11);
    @(negedge clk);
    drive1('0);

    // reset in the second BUSY cycle aborts the access without ack
    @(negedge clk);
    b3.if_req = 1; b3.if_addr = 32'h300; b3.ram_rdata = 32'hABCD_1234;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst3_n = 1'b0;
    #1;
    chk("rst_busy_cleared", {b3.ram_ce, b3.ram_we, b3.ram_addr, b3.if_ack}, '0);
    flag = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (b3.if_ack || b3.ram_ce) flag = 1'b1;
    end
    chk("rst_hold_quiet", flag, 1'b0);
    @(negedge clk);
    rst3_n = 1'b1;
    n = 0; nce = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (b3.ram_ce) nce++;
    end while (!b3.if_ack && n < 20);
    chk("rst_reserve_latency", n, 5);
    chk("rst_reserve_ce_cycles", nce, 4);
    chk("rst_reserve_rdata", b3.if_rdata, 32'hABCD_1234);
    @(negedge clk);
    b3.if_req = 0;

    // zero-wait back-to-back fetches: one ack every 3 cycles
    @(negedge clk);
    b0.if_req = 1; b0.if_addr = 32'h500; b0.ram_rdata = 32'h0000_0500;
    n = 0; na = 0; last = 0; ovl = 1'b0;
    while (na < 4 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (b0.if_ack && b0.dm_ack) ovl = 1'b1;
      if (b0.if_ack) begin
        if (na > 0) chk($sformatf("b2b_gap%0d", na), n - last, 3);
        last = n;
        na++;
      end
    end
    chk("b2b_acks", na, 4);

    // both ports contending at zero wait: acks still every 3 cycles, never together
    @(negedge clk);
    b0.dm_req = 1; b0.dm_we = 0; b0.dm_sel = 4'hF; b0.dm_addr = 32'h600;
    bad = 0; ifa = 0; dma = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      n++;
      if (b0.if_ack && b0.dm_ack) ovl = 1'b1;
      if (b0.if_ack || b0.dm_ack) begin
        if (n - last != 3) bad++;
        last = n;
        if (b0.if_ack) ifa++;
        if (b0.dm_ack) dma++;
        if (c >= 30) break;
      end
    end
    chk("mix_gap_errors", bad, 0);
    chk("mix_both_served", {ifa > 0, dma > 0}, 2'b11);
    chk("ack_overlap", ovl, 1'b0);
    @(negedge clk);
    b0.if_req = 0; b0.dm_req = 0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 1, extra RAM wait cycles per access (0..7).
REQ-002 SHALL have parameter MAX_STREAK, default 4, consecutive data grants before a pending fetch is forced (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports if_req input 1 fetch request; if_addr input 32 fetch address; if_rdata output 32 fetched word; if_ack output 1 fetch done.
REQ-006 SHALL have ports dm_req input 1; dm_we input 1; dm_sel input 4 byte lanes; dm_addr input 32; dm_wdata input 32; dm_rdata output 32; dm_ack output 1.
REQ-007 SHALL have ports ram_ce output 1; ram_we output 1; ram_sel output 4; ram_addr output 32; ram_wdata output 32; ram_rdata input 32.
REQ-008 SHALL have port stall_req  output  1  pipeline stall request to the CPU control unit.

Function
REQ-009 SHALL implement FSM IDLE, BUSY, DONE. IDLE->BUSY on any request. BUSY->DONE when the wait counter is 0. DONE->IDLE unconditionally.
REQ-010 SHALL in IDLE select the grant owner as follows: data if only dm_req; fetch if only if_req; data if both are high and streak<MAX_STREAK, else fetch.
REQ-011 SHALL on IDLE->BUSY register the owner's addr, sel and wdata into the ram_* outputs, together with ram_ce=1. ram_we SHALL equal dm_we for a data grant; a fetch grant SHALL drive ram_we=0 and ram_sel=4'hF.
REQ-012 SHALL hold all ram_* outputs stable throughout BUSY. ram_ce SHALL be high for exactly WAIT_CYC+1 cycles per access.
REQ-013 SHALL load the wait counter with WAIT_CYC on entering BUSY and decrement it once per BUSY cycle.
REQ-014 SHALL on BUSY->DONE clear ram_ce and ram_we. On a read it SHALL capture ram_rdata into the owner's rdata register.
REQ-015 SHALL assert the owner's ack for exactly the one DONE cycle. Latency from request sampled in IDLE to ack SHALL be WAIT_CYC+2 cycles.
REQ-016 SHALL ignore requests while in BUSY and DONE. A requester SHALL hold its request fields stable until its ack.
REQ-017 SHALL leave dm_rdata unchanged on a write and if_rdata unchanged when no fetch completes.
REQ-018 SHALL increment streak (saturating at MAX_STREAK) on each data grant made while if_req is high.
REQ-019 SHALL clear streak on a fetch grant, and on any IDLE cycle in which dm_req is low.
REQ-020 SHALL drive stall_req = (if_req & ~if_ack) | (dm_req & ~dm_ack), combinationally.
REQ-021 SHALL never assert if_ack and dm_ack in the same cycle.

Reset
REQ-022 SHALL on rst_n low immediately force state IDLE, counter 0, streak 0, all ram_* outputs 0, if_ack=dm_ack=0, and if_rdata=dm_rdata=0.
REQ-023 SHALL abort an access interrupted by reset mid-BUSY with no ack. After rst_n rises, the still-pending request SHALL be re-arbitrated from IDLE.

Structure
REQ-024 SHALL take the state enum, ADDR_W=32, DATA_W=32 and SEL_W=4 from shared package openmips_bus_pkg.
REQ-025 SHALL keep the arbitration, counter and FSM inline. No sub-module is required.

Verification
REQ-026 Single fetch: WAIT_CYC=1, if_req with if_addr=0x100 at edge 0, ram_rdata=0x3402_0020. Required: ram_ce high for 2 cycles, then if_ack=1 with if_rdata=0x3402_0020 at cycle 3, and stall_req high cycles 0-2.
REQ-027 Simultaneous requests: if_req and dm_req (read, 0x200) together. Required: data granted first, dm_ack at cycle 3, and the fetch completes 4 cycles later.
REQ-028 Write: dm_we=1, dm_sel=4'b0011, dm_wdata=0xDEAD_BEEF, addr 0x40. Required: ram_we=1 with ram_sel=0011 while ram_ce is high, dm_ack=1, and dm_rdata unchanged.
REQ-029 Starvation guard: MAX_STREAK=4, dm_req held continuously and if_req held. Required: the 5th grant goes to fetch and streak returns to 0.
REQ-030 Reset mid-BUSY: WAIT_CYC=3, rst_n low in the 2nd BUSY cycle. Required: ram_ce=0 and no ack. After release, the request is re-served with ack WAIT_CYC+2 cycles later.
REQ-031 WAIT_CYC=0 back-to-back fetches. Required: an ack every 3 cycles, and no ack overlap between the two ports.
